omem_write_sched: RTL and testbench
===================================

OMEM_WRITE_SCHED -- requirements
Module: omem_write_sched

Interface
REQ-001 Parameter BASE_W, default 8: tile base address width; OMEM_Addr width is BASE_W+2.
REQ-002 CLK  input  1  single clock; all logic on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 TILE_START  input  1  one-cycle pulse; begins a tile, sampled only in IDLE.
REQ-005 TILE_BASE  input  BASE_W  tile base address, latched when TILE_START is accepted.
REQ-006 ROW_VALID  input  4  per-row request: row i holds a completed 64-bit result.
REQ-007 ROW_DATA  input  256  row i data at bits [64*i+63 : 64*i]; stable while ROW_VALID[i]=1.
REQ-008 ROW_ACK  output  4  one-hot, one-cycle pulse; row i data captured, requester deasserts ROW_VALID[i].
REQ-009 OMEM_Ready  input  1  output memory accepts the write in the current cycle.
REQ-010 OMEM_Write  output  1  write request to output memory.
REQ-011 OMEM_Addr  output  BASE_W+2  write address {base_latched, row[1:0]}.
REQ-012 OMEM_Data  output  64  write data.
REQ-013 Tile_Done  output  1  one-cycle pulse after all 4 rows are written.
REQ-014 Busy  output  1  high in every state except IDLE.
REQ-015 ERR  output  1  sticky: TILE_START received while Busy.

Function
REQ-016 The FSM SHALL have states IDLE, ARB, WRITE, DONE, plus a 4-bit served mask, a 2-bit grant register and a 2-bit round-robin pointer.
REQ-017 In IDLE, TILE_START=1 SHALL latch TILE_BASE, clear served, and go to ARB.
REQ-018 In ARB, eligible = ROW_VALID & ~served; if eligible is zero, the FSM SHALL stay in ARB indefinitely.
REQ-019 In ARB with eligible nonzero, the block SHALL choose a row per REQ-033/034, latch its ROW_DATA into OMEM_Data and the address into OMEM_Addr, and go to WRITE.
REQ-020 ROW_ACK[g] SHALL be 1 only in the first cycle of WRITE for granted row g.
REQ-021 In WRITE, OMEM_Write SHALL be 1, and OMEM_Addr/OMEM_Data SHALL stay stable until a cycle with OMEM_Ready=1.
REQ-022 On the OMEM_Ready=1 cycle, the block SHALL set served[g] and go to DONE if served becomes 4'b1111, else to ARB.
REQ-023 Outside WRITE, OMEM_Write SHALL be 0; OMEM_Addr/OMEM_Data hold their last values.
REQ-024 In DONE, Tile_Done SHALL be 1 for exactly one cycle; next state SHALL be IDLE.
REQ-025 ROW_VALID on an already-served row SHALL be ignored (no ack, no write).
REQ-026 TILE_START while Busy SHALL be ignored and SHALL set ERR; only RST clears ERR.
REQ-027 Best-case latency with OMEM_Ready tied 1 and all rows valid: TILE_START sampled at edge 0 gives OMEM_Write high in cycles 2, 4, 6, 8 and Tile_Done in cycle 9.
REQ-028 Each row SHALL be written exactly once per tile, in any order; addresses are base*4+row.

Reset
REQ-029 While RST=1 at a rising edge, the block SHALL clear: state to IDLE; served, grant and RR pointer to 0; OMEM_Write, ROW_ACK, Tile_Done, Busy and ERR to 0; OMEM_Addr and OMEM_Data to 0.
REQ-030 Reset mid-tile SHALL drop any in-flight write with no further ack; the next tile starts clean.
REQ-031 There SHALL be no asynchronous reset path.

Configuration
REQ-032 The macro OSCHED_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-033 Defined: round-robin. Search starts at pointer; after each grant g, pointer = g+1 mod 4. The pointer persists across tiles.
REQ-034 Undefined: fixed priority, row 0 highest, row 3 lowest; there is no pointer register.

Verification
REQ-035 Base=8'h05, all ROW_VALID=1, Ready=1, RR off -> writes at addr 0x014, 0x015, 0x016, 0x017 in cycles 2, 4, 6, 8 with matching data; Tile_Done in cycle 9.
REQ-036 Ready held 0 for 3 cycles during the first write -> OMEM_Write, Addr and Data stay stable for 4 cycles; ROW_ACK pulses once only.
REQ-037 RR on, two tiles with all rows valid -> tile 1 order 0,1,2,3; tile 2 order 0,1,2,3 (pointer wrapped); with only rows 2,3 valid at tile 2 start, order is 2,3 then 0,1 as they rise.
REQ-038 TILE_START pulsed in cycle 4 of a tile -> ERR=1 and stays 1; tile completes unchanged; RST clears ERR.
REQ-039 RST asserted during WRITE with Ready=0 -> next cycle all outputs 0 and state IDLE; a new TILE_START yields 4 fresh writes.
REQ-040 Row 1 ROW_VALID held high after its ack -> no second write of row 1; Tile_Done only after rows 0, 2 and 3 are also written.

Source files
------------

// File: rtl/omem_write_sched.sv
// omem_write_sched: collects the four 64-bit row results of a tile. Each
// row is written once into the output memory at address {tile_base, row},
// and the tile ends with a one-cycle Tile_Done pulse.
// Build option: define OSCHED_ROUND_ROBIN_EN for round-robin row
// arbitration with a pointer that persists across tiles. When it is left
// undefined, arbitration is fixed priority with row 0 highest.
module omem_write_sched #(
    parameter int BASE_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TILE_START,
    input  logic [BASE_W-1:0] TILE_BASE,
    input  logic [3:0]        ROW_VALID,
    input  logic [255:0]      ROW_DATA,
    output logic [3:0]        ROW_ACK,
    input  logic              OMEM_Ready,
    output logic              OMEM_Write,
    output logic [BASE_W+1:0] OMEM_Addr,
    output logic [63:0]       OMEM_Data,
    output logic              Tile_Done,
    output logic              Busy,
    output logic              ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [BASE_W-1:0] base;
    logic [3:0]        served;
    logic [1:0]        grant;
`ifdef OSCHED_ROUND_ROBIN_EN
    logic [1:0]        rr_ptr;
`endif

    logic [3:0]        eligible;
    logic              pick_valid;
    logic [1:0]        pick;
    logic [3:0]        served_next;

    // Select the next unserved requesting row and precompute the served mask after the current write.
    // NOTE: every signal driven here gets a default value first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        eligible    = ROW_VALID & ~served;
        pick_valid  = |eligible;
        pick        = 2'd0;
`ifdef OSCHED_ROUND_ROBIN_EN
        // Scan from the farthest offset down to the nearest one, so the row closest to the pointer wins.
        for (int k = 3; k >= 0; k--) begin
            if (eligible[rr_ptr + 2'(k)]) pick = rr_ptr + 2'(k);
        end
`else
        // Scan from the highest row index down, so the lowest index wins.
        for (int k = 3; k >= 0; k--) begin
            if (eligible[2'(k)]) pick = 2'(k);
        end
`endif
        served_next = served | (4'b0001 << grant);
    end

    // Tile sequencing FSM; all outputs are registered.
    // NOTE: state is updated only with non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the address and data registers are cleared as well, because the outputs must read zero after reset.
            state      <= IDLE;
            base       <= '0;
            served     <= '0;
            grant      <= '0;
`ifdef OSCHED_ROUND_ROBIN_EN
            rr_ptr     <= '0;
`endif
            ROW_ACK    <= '0;
            OMEM_Write <= 1'b0;
            OMEM_Addr  <= '0;
            OMEM_Data  <= '0;
            Tile_Done  <= 1'b0;
            Busy       <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            ROW_ACK   <= '0;
            Tile_Done <= 1'b0;

            // A start request that arrives mid-tile is dropped and recorded as an error.
            if (TILE_START && state != IDLE) ERR <= 1'b1;

            case (state)
                IDLE: begin
                    if (TILE_START) begin
                        base   <= TILE_BASE;
                        served <= '0;
                        Busy   <= 1'b1;
                        state  <= ARB;
                    end
                end
                ARB: begin
                    if (pick_valid) begin
                        grant      <= pick;
                        OMEM_Addr  <= {base, pick};
                        OMEM_Data  <= ROW_DATA[{pick, 6'd0} +: 64];
                        OMEM_Write <= 1'b1;
                        ROW_ACK    <= 4'b0001 << pick;
`ifdef OSCHED_ROUND_ROBIN_EN
                        rr_ptr     <= pick + 2'd1;
`endif
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    // Address and data stay frozen until the memory accepts the write.
                    if (OMEM_Ready) begin
                        served     <= served_next;
                        OMEM_Write <= 1'b0;
                        if (served_next == 4'b1111) begin
                            Tile_Done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state     <= ARB;
                        end
                    end
                end
                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_omem_write_sched.sv
// tb_omem_write_sched: drives tiles from a struct table, a few hand-written
// sequences and a randomized loop. Expected behaviour comes from tile-level
// rules: the grant order, addresses of base*4+row, the row data, the
// best-case cycle arithmetic and the sticky error flag.
module tb_omem_write_sched;

    logic         CLK = 1'b0;
    logic         RST;
    logic         TILE_START;
    logic [7:0]   TILE_BASE;
    logic [3:0]   ROW_VALID;
    logic [255:0] ROW_DATA;
    logic [3:0]   ROW_ACK;
    logic         OMEM_Ready;
    logic         OMEM_Write;
    logic [9:0]   OMEM_Addr;
    logic [63:0]  OMEM_Data;
    logic         Tile_Done;
    logic         Busy;
    logic         ERR;

    int   total = 0;
    int   bad   = 0;
    logic err_model = 1'b0;

    always #5 CLK = ~CLK;

    omem_write_sched #(.BASE_W(8)) dut (
        .CLK(CLK), .RST(RST), .TILE_START(TILE_START), .TILE_BASE(TILE_BASE),
        .ROW_VALID(ROW_VALID), .ROW_DATA(ROW_DATA), .ROW_ACK(ROW_ACK),
        .OMEM_Ready(OMEM_Ready), .OMEM_Write(OMEM_Write), .OMEM_Addr(OMEM_Addr),
        .OMEM_Data(OMEM_Data), .Tile_Done(Tile_Done), .Busy(Busy), .ERR(ERR)
    );

    // One tile: the rows valid at start are perm[0..pre-1], given in their expected grant order.
    // Each later perm[j] rises only after j acks plus 'gap' cycles, so perm is always the expected write order.
    typedef struct {
        bit         rst;
        logic [7:0] base;
        int         pre;
        logic [7:0] perm;
        int         stall;
        logic [3:0] hold;
        int         err_cyc;
        int         gap;
        bit         timed;
        bit         rnd;
    } tile_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] row_at(input logic [7:0] perm, input int j);
        return perm[2*j +: 2];
    endfunction

    task automatic do_reset();
        RST = 1'b1; TILE_START = 1'b0; TILE_BASE = '0;
        ROW_VALID = '0; ROW_DATA = '0; OMEM_Ready = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        err_model = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ack"},   64'(ROW_ACK),    64'd0);
        check({tag, "_write"}, 64'(OMEM_Write), 64'd0);
        check({tag, "_addr"},  64'(OMEM_Addr),  64'd0);
        check({tag, "_data"},  OMEM_Data,       64'd0);
        check({tag, "_done"},  64'(Tile_Done),  64'd0);
        check({tag, "_busy"},  64'(Busy),       64'd0);
        check({tag, "_err"},   64'(ERR),        64'd0);
    endtask

    task automatic run_tile(input tile_t t);
        logic [63:0] rd [4];
        logic [3:0]  raised;
        logic [9:0]  p_addr;
        logic [63:0] p_data;
        int          cyc, k_ack, k_wr, wcyc, last_ack, done_cyc, row;
        bit          stalled, just_done;

        if (t.rst) do_reset();
        for (int i = 0; i < 4; i++)
            rd[i] = t.rnd ? {$urandom(), $urandom()}
                          : (64'hA5A5_0000_0000_0000 | (64'(t.base) << 8) | 64'(i));
        ROW_DATA = {rd[3], rd[2], rd[1], rd[0]};
        raised = '0;
        for (int j = 0; j < t.pre; j++) raised[row_at(t.perm, j)] = 1'b1;
        ROW_VALID  = raised;
        TILE_BASE  = t.base;
        TILE_START = 1'b1;
        OMEM_Ready = 1'($urandom_range(0, 1));
        @(posedge CLK); #1;
        TILE_START = 1'b0;
        TILE_BASE  = 8'($urandom());

        cyc = 1; k_ack = 0; k_wr = 0; wcyc = 0; last_ack = 0; done_cyc = -1;
        stalled = 1'b0; just_done = 1'b0; p_addr = '0; p_data = '0; row = 0;
        while (cyc < 300) begin
            if (ROW_ACK != 4'b0000) begin
                if (k_ack < 4) begin
                    check("ack_row", 64'(ROW_ACK), 64'(4'b0001 << row_at(t.perm, k_ack)));
                    check("ack_in_write", 64'(OMEM_Write), 64'd1);
                end else begin
                    check("extra_ack", 64'(ROW_ACK), 64'd0);
                end
                k_ack++;
                last_ack = cyc;
                wcyc = 0;
                ROW_VALID = ROW_VALID & ~(ROW_ACK & ~t.hold);
            end

            if (just_done) begin
                check("write_drop", 64'(OMEM_Write), 64'd0);
                check("addr_hold", 64'(OMEM_Addr), 64'(p_addr));
                check("data_hold", OMEM_Data, p_data);
            end
            if (stalled) begin
                check("write_held", 64'(OMEM_Write), 64'd1);
                check("addr_stable", 64'(OMEM_Addr), 64'(p_addr));
                check("data_stable", OMEM_Data, p_data);
            end
            just_done = 1'b0;

            if (OMEM_Write) begin
                wcyc++;
                OMEM_Ready = (wcyc > t.stall);
                if (OMEM_Ready) begin
                    if (k_wr < 4) begin
                        row = int'(row_at(t.perm, k_wr));
                        check("wr_addr", 64'(OMEM_Addr), 64'(t.base) * 64'd4 + 64'(row));
                        check("wr_data", OMEM_Data, rd[row]);
                        if (t.timed)
                            check("wr_cycle", 64'(cyc), 64'(2 + k_wr * (t.stall + 2) + t.stall));
                    end else begin
                        check("extra_write", 64'(k_wr), 64'd3);
                    end
                    k_wr++;
                    just_done = 1'b1;
                end
                stalled = !OMEM_Ready;
                p_addr  = OMEM_Addr;
                p_data  = OMEM_Data;
            end else begin
                stalled    = 1'b0;
                OMEM_Ready = 1'($urandom_range(0, 1));
            end

            check("busy", 64'(Busy), 64'd1);
            if (Tile_Done) begin
                done_cyc = cyc;
                check("done_rows", 64'(k_wr), 64'd4);
                if (t.timed) check("done_cycle", 64'(cyc), 64'(9 + 4 * t.stall));
                break;
            end

            for (int j = t.pre; j < 4; j++) begin
                if (!raised[row_at(t.perm, j)] && k_ack >= j && cyc >= last_ack + t.gap) begin
                    raised[row_at(t.perm, j)]    = 1'b1;
                    ROW_VALID[row_at(t.perm, j)] = 1'b1;
                end
            end

            TILE_START = (cyc == t.err_cyc);
            if (TILE_START) err_model = 1'b1;
            @(posedge CLK); #1;
            cyc++;
        end

        check("tile_done_seen", 64'(done_cyc >= 0), 64'd1);
        check("ack_count", 64'(k_ack), 64'd4);
        TILE_START = 1'b0;
        ROW_VALID  = '0;
        @(posedge CLK); #1;
        check("done_one_cycle", 64'(Tile_Done), 64'd0);
        check("idle_busy", 64'(Busy), 64'd0);
        check("idle_write", 64'(OMEM_Write), 64'd0);
        check("err_flag", 64'(ERR), 64'(err_model));
    endtask

    initial begin
        tile_t tbl [6];
        tile_t t;
        int    p [4];
        int    j, tmp;

        tbl[0] = '{rst: 1'b0, base: 8'h05, pre: 4, perm: 8'hE4, stall: 0, hold: 4'h0, err_cyc: 0, gap: 0, timed: 1'b1, rnd: 1'b0};
        tbl[1] = '{rst: 1'b0, base: 8'h3A, pre: 4, perm: 8'hE4, stall: 3, hold: 4'h0, err_cyc: 0, gap: 0, timed: 1'b1, rnd: 1'b1};
        tbl[2] = '{rst: 1'b0, base: 8'hFF, pre: 4, perm: 8'hE4, stall: 0, hold: 4'h0, err_cyc: 0, gap: 0, timed: 1'b1, rnd: 1'b1};
        tbl[3] = '{rst: 1'b0, base: 8'h00, pre: 2, perm: 8'h4E, stall: 1, hold: 4'h0, err_cyc: 0, gap: 2, timed: 1'b0, rnd: 1'b1};
        tbl[4] = '{rst: 1'b1, base: 8'h81, pre: 4, perm: 8'hE4, stall: 1, hold: 4'h2, err_cyc: 0, gap: 0, timed: 1'b1, rnd: 1'b1};
        tbl[5] = '{rst: 1'b0, base: 8'h42, pre: 4, perm: 8'hE4, stall: 0, hold: 4'h0, err_cyc: 4, gap: 0, timed: 1'b1, rnd: 1'b0};

        // Check the outputs while reset is still applied, then release it.
        RST = 1'b1; TILE_START = 1'b0; TILE_BASE = '0;
        ROW_VALID = '0; ROW_DATA = '0; OMEM_Ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_idle("reset");
        RST = 1'b0;

        for (int i = 0; i < 6; i++) run_tile(tbl[i]);

        // ERR is sticky through idle cycles and is cleared only by reset.
        repeat (3) @(posedge CLK);
        #1;
        check("err_sticky", 64'(ERR), 64'd1);
        do_reset();
        check("err_cleared", 64'(ERR), 64'd0);

        // Apply reset while the first write is stalled, then check that the next tile starts clean.
        ROW_DATA = {4{64'hDEAD_BEEF_0000_0001}};
        ROW_VALID = 4'hF; TILE_BASE = 8'h11; TILE_START = 1'b1; OMEM_Ready = 1'b0;
        @(posedge CLK); #1;
        TILE_START = 1'b0;
        @(posedge CLK); #1;
        check("mid_write", 64'(OMEM_Write), 64'd1);
        check("mid_ack", 64'(ROW_ACK), 64'd1);
        @(posedge CLK); #1;
        check("mid_ack_once", 64'(ROW_ACK), 64'd0);
        check("mid_addr", 64'(OMEM_Addr), 64'h044);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; ROW_VALID = '0; err_model = 1'b0;
        check_idle("mid_rst");
        @(posedge CLK); #1;
        check("post_rst_ack", 64'(ROW_ACK), 64'd0);
        check("post_rst_write", 64'(OMEM_Write), 64'd0);
        t = '{rst: 1'b0, base: 8'h6C, pre: 4, perm: 8'hE4, stall: 0, hold: 4'h0, err_cyc: 0, gap: 0, timed: 1'b1, rnd: 1'b1};
        run_tile(t);

        // Random tiles: each row rises only after the previous ack, so the expected order is the shuffle itself.
        for (int n = 0; n < 25; n++) begin
            p = '{0, 1, 2, 3};
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = p[i]; p[i] = p[j]; p[j] = tmp;
            end
            t.rst     = ($urandom_range(0, 9) == 0);
            t.base    = 8'($urandom());
            t.pre     = 1;
            for (int i = 0; i < 4; i++) t.perm[2*i +: 2] = 2'(p[i]);
            t.stall   = $urandom_range(0, 3);
            t.hold    = 4'($urandom());
            t.err_cyc = ($urandom_range(0, 5) == 0) ? 5 : 0;
            t.gap     = $urandom_range(0, 3);
            t.timed   = 1'b0;
            t.rnd     = 1'b1;
            run_tile(t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
